// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source selects, load funct3 codes
// and FSM state values.
package wb_pkg;

  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_LOAD = 2'b01;
  localparam logic [1:0] WB_SRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extractor: picks the byte/halfword addressed by the low
// address bits and sign- or zero-extends it according to funct3.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rdata_i[7:0];
    case (off_i)
      2'd0: byteSel = rdata_i[7:0];
      2'd1: byteSel = rdata_i[15:8];
      2'd2: byteSel = rdata_i[23:16];
      2'd3: byteSel = rdata_i[31:24];
      default: byteSel = rdata_i[7:0];
    endcase
    halfSel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Undefined funct3 codes fall through to a full-word load.
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byteSel[7]}}, byteSel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byteSel};
      F3_LH:   data_o = {{(XLEN-16){halfSel[15]}}, halfSel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, halfSel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Pipeline write-back stage: retires one instruction per MEM handshake and drives the
// register-file write port. Define WB_TIMEOUT_EN to add the load-response watchdog.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32
`ifdef WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_MEM,
  output logic            ready_MEM,
  input  logic            RegWrite_MEM,
  input  logic [1:0]      MemToReg_MEM,
  input  logic [4:0]      RD_MEM,
  input  logic [XLEN-1:0] ALU_RESULT_MEM,
  input  logic [XLEN-1:0] PC_MEM,
  input  logic [2:0]      FUNCT3_MEM,
  input  logic            DMEM_RVALID,
  input  logic [XLEN-1:0] DMEM_RDATA,
`ifdef WB_TIMEOUT_EN
  output logic            LOAD_TIMEOUT,
`endif
  output logic            RegWrite_WB,
  output logic [4:0]      RD_WB,
  output logic [XLEN-1:0] ALU_DATA_WB,
  output logic            STALL_WB
);

  logic [0:0]      state_q, state_d;
  logic            capRegWrite_q, capRegWrite_d;
  logic [4:0]      capRd_q, capRd_d;
  logic [1:0]      capOff_q, capOff_d;
  logic [2:0]      capFunct3_q, capFunct3_d;
  logic            regWriteWb_q, regWriteWb_d;
  logic [4:0]      rdWb_q, rdWb_d;
  logic [XLEN-1:0] dataWb_q, dataWb_d;
  logic [XLEN-1:0] extData;
  logic            transfer;

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wdogCnt_q, wdogCnt_d;
  logic          timeout_q, timeout_d;
  assign LOAD_TIMEOUT = timeout_q;
`endif

  assign ready_MEM   = (state_q == ST_IDLE);
  assign STALL_WB    = (state_q == ST_WAIT);
  assign transfer    = valid_MEM && ready_MEM;
  assign RegWrite_WB = regWriteWb_q;
  assign RD_WB       = rdWb_q;
  assign ALU_DATA_WB = dataWb_q;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i (capFunct3_q),
    .off_i    (capOff_q),
    .rdata_i  (DMEM_RDATA),
    .data_o   (extData)
  );

  always_comb begin
    state_d       = state_q;
    capRegWrite_d = capRegWrite_q;
    capRd_d       = capRd_q;
    capOff_d      = capOff_q;
    capFunct3_d   = capFunct3_q;
    regWriteWb_d  = 1'b0;
    rdWb_d        = rdWb_q;
    dataWb_d      = dataWb_q;
`ifdef WB_TIMEOUT_EN
    wdogCnt_d     = wdogCnt_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          capRegWrite_d = RegWrite_MEM;
          capRd_d       = RD_MEM;
          capOff_d      = ALU_RESULT_MEM[1:0];
          capFunct3_d   = FUNCT3_MEM;
          if (MemToReg_MEM == WB_SRC_LOAD) begin
            state_d = ST_WAIT;
`ifdef WB_TIMEOUT_EN
            wdogCnt_d = '0;
`endif
          end else begin
            regWriteWb_d = RegWrite_MEM && (RD_MEM != 5'd0);
            rdWb_d       = RD_MEM;
            dataWb_d     = (MemToReg_MEM == WB_SRC_PC4) ? PC_MEM + XLEN'(4) : ALU_RESULT_MEM;
          end
        end
      end
      ST_WAIT: begin
        // A response arriving on the watchdog's last cycle still completes normally.
        if (DMEM_RVALID) begin
          regWriteWb_d = capRegWrite_q && (capRd_q != 5'd0);
          rdWb_d       = capRd_q;
          dataWb_d     = extData;
          state_d      = ST_IDLE;
        end
`ifdef WB_TIMEOUT_EN
        else if (wdogCnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wdogCnt_d = wdogCnt_q + CW'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      capRegWrite_q <= 1'b0;
      capRd_q       <= 5'd0;
      capOff_q      <= 2'd0;
      capFunct3_q   <= 3'd0;
      regWriteWb_q  <= 1'b0;
      rdWb_q        <= 5'd0;
      dataWb_q      <= '0;
`ifdef WB_TIMEOUT_EN
      wdogCnt_q     <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      capRegWrite_q <= capRegWrite_d;
      capRd_q       <= capRd_d;
      capOff_q      <= capOff_d;
      capFunct3_q   <= capFunct3_d;
      regWriteWb_q  <= regWriteWb_d;
      rdWb_q        <= rdWb_d;
      dataWb_q      <= dataWb_d;
`ifdef WB_TIMEOUT_EN
      wdogCnt_q     <= wdogCnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

endmodule
